btn_gesture_decoder: RTL and testbench
======================================

Name: btn_gesture_decoder

Overview:
Downstream consumer of the button debouncer's `click` pulse and `long_press` level. It classifies user gestures into discrete events: single, double or multi click, long-press start (with the number of preceding taps), and long-press end. Events go out on a valid/ready interface to the system control logic, for example a mode selector or a UART command injector. Tap grouping uses a configurable inter-click gap window.

Parameters:
CLK_FREQUENCY, 100000000, clock frequency in Hz.
CLICK_INPUT_LEVEL, 1, active level of `click`.
LONG_PRESS_INPUT_LEVEL, 1, active level of `long_press`.
GAP_MS, 300, maximum gap between clicks of one group. Derived localparam GAP_CLKS = CLK_FREQUENCY/1000*GAP_MS, forced to 1 when that is 0.
MAX_CLICKS, 3, click count that closes a group immediately. Must be >= 1.
HOLD_W, 16, width of the hold-time output (optional feature only).
Localparam CNT_W = $clog2(MAX_CLICKS+1).

Ports:
clk  in  1  system clock.
reset_n  in  1  synchronous, active-low reset.
click  in  1  debounced click, one active cycle per press.
long_press  in  1  long-press level, active while the button is held past threshold.
evt_valid  out  1  event available.
evt_ready  in  1  consumer accepts the event when it is high together with evt_valid.
evt_type  out  2  0=CLICK, 1=LONG_START, 2=LONG_END (3 is never driven).
evt_clicks  out  CNT_W  click count attached to the event.
evt_overrun  out  1  sticky flag: an event was dropped.

Behaviour:
- Reset (reset_n=0 at a clk edge) sets:
  - FSM=IDLE, tap count=0, gap timer=0, edge registers=inactive;
  - evt_valid=0, evt_type=0, evt_clicks=0, evt_overrun=0.
- Edge detection:
  - Inputs are sampled each cycle and compared with the previous sample.
  - A click edge is an inactive-to-CLICK_INPUT_LEVEL transition. A held `click` counts once.
  - A long-press rise or fall is a transition to or from LONG_PRESS_INPUT_LEVEL.
- FSM states: IDLE, COUNT, LONG.
- IDLE:
  - Click edge: go to COUNT, count=1, timer=0. If MAX_CLICKS==1, instead emit CLICK(1) and stay in IDLE.
  - Long-press rise: emit LONG_START(clicks=0) and go to LONG.
- COUNT:
  - Each cycle with no edge, the timer increments, saturating.
  - Click edge: count+1 and timer=0. If count+1==MAX_CLICKS, emit CLICK(MAX_CLICKS) and go to IDLE.
  - Timer==GAP_CLKS-1 with no edge: emit CLICK(count) and go to IDLE.
  - Long-press rise: emit LONG_START(clicks=count) and go to LONG. The count includes the hold's own click.
- LONG:
  - Click edges are ignored.
  - Long-press fall: emit LONG_END(clicks=0) and go to IDLE.
- Simultaneous click edge and long-press rise:
  - Long wins. The click is added to the count first, then LONG_START(count) is emitted.
  - In IDLE this gives LONG_START(1).
  - The MAX_CLICKS check is skipped in this case.
- Timing:
  - Emission is registered: evt_valid rises the cycle after the deciding edge or timer condition.
  - A lone click high in cycle t gives evt_valid in cycle t+GAP_CLKS+1.
- Handshake:
  - evt_valid, evt_type and evt_clicks are held stable until evt_valid && evt_ready. evt_valid falls the following cycle unless a new event loads.
  - A new event in the same cycle as acceptance loads directly; evt_valid stays high.
  - A new event while evt_valid=1 and evt_ready=0 is dropped: evt_overrun is set, and the FSM still advances.
  - evt_overrun is cleared only by reset.
- Reset mid-gesture discards partial counts; no event is emitted.
- `long_press` already active when reset releases: the previous sample resets to inactive, so a LONG_START(0) fires on the first cycle after reset.

Optional Feature:
Macro BTN_GESTURE_HOLD_TIME_EN.
- Defined:
  - Adds output port `evt_hold_ms [HOLD_W-1:0]`.
  - A millisecond counter (prescaler of CLK_FREQUENCY/1000 clocks) clears on long-press rise and saturates at all-ones.
  - LONG_END carries the elapsed ms in evt_hold_ms.
  - All other events drive evt_hold_ms=0.
  - Reset value is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
Bench config for all scenarios: CLK_FREQUENCY=1000 (1 clk/ms), GAP_MS=5, MAX_CLICKS=3, evt_ready=1 unless stated.
1. click high in cycle 10 only -> evt_valid=1 in cycle 16 only, evt_type=0, evt_clicks=1.
2. clicks in cycles 10 and 13 -> one event in cycle 19, CLICK, clicks=2. Nothing at cycle 16.
3. clicks in cycles 10, 12, 14 -> CLICK(3) in cycle 15. No further event.
4. click in cycle 10, long_press high in cycles 12–40 -> LONG_START(clicks=1) in cycle 13, LONG_END(0) in cycle 42. With the macro defined, evt_hold_ms=29.
5. evt_ready=0 from cycle 0, click in cycle 10, long_press high in cycles 20–30 -> CLICK(1) held from cycle 16. The LONG_START and LONG_END are dropped and evt_overrun=1. Raising evt_ready in cycle 35 -> evt_valid low in cycle 36, evt_overrun stays 1.
6. clicks in cycles 10 and 12, reset_n=0 in cycle 13 -> no event ever emitted. A click in cycle 20 -> CLICK(1) in cycle 26.

Source files
------------

// File: rtl/btn_gesture_decoder.sv
// Classifies debounced click pulses and long-press levels into CLICK / LONG_START / LONG_END events.
// Define BTN_GESTURE_HOLD_TIME_EN to add the evt_hold_ms port carrying long-press duration.
module btn_gesture_decoder #(
  parameter int CLK_FREQUENCY          = 100000000,
  parameter int CLICK_INPUT_LEVEL      = 1,
  parameter int LONG_PRESS_INPUT_LEVEL = 1,
  parameter int GAP_MS                 = 300,
  parameter int MAX_CLICKS             = 3,
  parameter int HOLD_W                 = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              click,
  input  logic                              long_press,
  output logic                              evt_valid,
  input  logic                              evt_ready,
  output logic [1:0]                        evt_type,
  output logic [$clog2(MAX_CLICKS+1)-1:0]   evt_clicks,
  output logic                              evt_overrun
`ifdef BTN_GESTURE_HOLD_TIME_EN
  ,
  output logic [HOLD_W-1:0]                 evt_hold_ms
`endif
);

  localparam int CNT_W    = $clog2(MAX_CLICKS + 1);
  localparam int GAP_RAW  = CLK_FREQUENCY / 1000 * GAP_MS;
  localparam int GAP_CLKS = (GAP_RAW < 1) ? 1 : GAP_RAW;
  localparam int TMR_W    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GAP_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CLICKS);

  if (MAX_CLICKS < 1 || HOLD_W < 1) begin : g_param_check
    $error("btn_gesture_decoder: MAX_CLICKS and HOLD_W must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    LONG
  } state_e;

  typedef enum logic [1:0] {
    EVT_CLICK      = 2'd0,
    EVT_LONG_START = 2'd1,
    EVT_LONG_END   = 2'd2
  } evt_type_e;

  state_e           state, state_next;
  logic [CNT_W-1:0] count, count_next, count_inc;
  logic [TMR_W-1:0] timer, timer_next;

  logic      click_act, long_act;
  logic      click_prev, long_prev;
  logic      click_edge, long_rise, long_fall;

  logic             emit;
  evt_type_e        emit_type;
  logic [CNT_W-1:0] emit_clicks;

  // Inputs are normalised to active-high before edge detection.
  assign click_act  = (click == 1'(CLICK_INPUT_LEVEL));
  assign long_act   = (long_press == 1'(LONG_PRESS_INPUT_LEVEL));
  assign click_edge = click_act & ~click_prev;
  assign long_rise  = long_act & ~long_prev;
  assign long_fall  = ~long_act & long_prev;
  assign count_inc  = count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      click_prev <= 1'b0;
      long_prev  <= 1'b0;
    end else begin
      click_prev <= click_act;
      long_prev  <= long_act;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      timer <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      timer <= timer_next;
    end
  end

  // Long-press rise takes priority over a coincident click edge.
  always_comb begin
    state_next = state;
    count_next = count;
    timer_next = timer;
    case (state)
      IDLE: begin
        if (long_rise) begin
          state_next = LONG;
          count_next = '0;
          timer_next = '0;
        end else if (click_edge && MAX_CLICKS > 1) begin
          state_next = COUNT;
          count_next = CNT_W'(1);
          timer_next = '0;
        end
      end
      COUNT: begin
        if (long_rise) begin
          state_next = LONG;
          count_next = '0;
          timer_next = '0;
        end else if (click_edge) begin
          timer_next = '0;
          if (count_inc == CNT_MAX) begin
            state_next = IDLE;
            count_next = '0;
          end else begin
            count_next = count_inc;
          end
        end else if (timer == TMR_LAST) begin
          state_next = IDLE;
          count_next = '0;
          timer_next = '0;
        end else if (timer != '1) begin
          timer_next = timer + TMR_W'(1);
        end
      end
      LONG: begin
        if (long_fall) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
        timer_next = '0;
      end
    endcase
  end

  always_comb begin
    emit        = 1'b0;
    emit_type   = EVT_CLICK;
    emit_clicks = '0;
    case (state)
      IDLE: begin
        if (long_rise) begin
          emit        = 1'b1;
          emit_type   = EVT_LONG_START;
          emit_clicks = click_edge ? CNT_W'(1) : '0;
        end else if (click_edge && MAX_CLICKS == 1) begin
          emit        = 1'b1;
          emit_clicks = CNT_W'(1);
        end
      end
      COUNT: begin
        if (long_rise) begin
          emit        = 1'b1;
          emit_type   = EVT_LONG_START;
          emit_clicks = click_edge ? count_inc : count;
        end else if (click_edge && count_inc == CNT_MAX) begin
          emit        = 1'b1;
          emit_clicks = CNT_MAX;
        end else if (!click_edge && timer == TMR_LAST) begin
          emit        = 1'b1;
          emit_clicks = count;
        end
      end
      LONG: begin
        if (long_fall) begin
          emit      = 1'b1;
          emit_type = EVT_LONG_END;
        end
      end
      default: ;
    endcase
  end

`ifdef BTN_GESTURE_HOLD_TIME_EN
  localparam int PRESC_RAW = CLK_FREQUENCY / 1000;
  localparam int PRESC     = (PRESC_RAW < 1) ? 1 : PRESC_RAW;
  localparam int PRE_W     = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESC - 1);

  logic [PRE_W-1:0]  pre_cnt;
  logic [HOLD_W-1:0] ms_cnt, ms_now, emit_hold;
  logic              ms_tick;

  // ms_now includes the current cycle's tick so the fall edge reports the full hold.
  assign ms_tick   = (pre_cnt == PRE_LAST);
  assign ms_now    = (ms_tick && ms_cnt != '1) ? ms_cnt + HOLD_W'(1) : ms_cnt;
  assign emit_hold = (emit_type == EVT_LONG_END) ? ms_now : '0;

  always_ff @(posedge clk) begin
    if (!reset_n || long_rise) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else begin
      pre_cnt <= ms_tick ? '0 : pre_cnt + PRE_W'(1);
      ms_cnt  <= ms_now;
    end
  end
`endif

  // Events arriving while an unaccepted one is pending are dropped and flagged.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      evt_valid   <= 1'b0;
      evt_type    <= 2'd0;
      evt_clicks  <= '0;
      evt_overrun <= 1'b0;
`ifdef BTN_GESTURE_HOLD_TIME_EN
      evt_hold_ms <= '0;
`endif
    end else if (emit) begin
      if (!evt_valid || evt_ready) begin
        evt_valid  <= 1'b1;
        evt_type   <= emit_type;
        evt_clicks <= emit_clicks;
`ifdef BTN_GESTURE_HOLD_TIME_EN
        evt_hold_ms <= emit_hold;
`endif
      end else begin
        evt_overrun <= 1'b1;
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_gesture_decoder.sv
// Directed-vector bench for btn_gesture_decoder at 1 clk/ms, 5 ms gap, 3-click groups.
// Each scenario starts from reset; cycle 0 is the first cycle with reset_n released.
module tb_btn_gesture_decoder;

  localparam int CNT_W  = 2;
  localparam int HOLD_W = 16;
  localparam int NCYC   = 50;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             click;
  logic             long_press;
  logic             evt_ready;
  logic             evt_valid;
  logic [1:0]       evt_type;
  logic [CNT_W-1:0] evt_clicks;
  logic             evt_overrun;
`ifdef BTN_GESTURE_HOLD_TIME_EN
  logic [HOLD_W-1:0] evt_hold_ms;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  btn_gesture_decoder #(
    .CLK_FREQUENCY         (1000),
    .CLICK_INPUT_LEVEL     (1),
    .LONG_PRESS_INPUT_LEVEL(1),
    .GAP_MS                (5),
    .MAX_CLICKS            (3),
    .HOLD_W                (HOLD_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .click      (click),
    .long_press (long_press),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_type   (evt_type),
    .evt_clicks (evt_clicks),
    .evt_overrun(evt_overrun)
`ifdef BTN_GESTURE_HOLD_TIME_EN
    ,
    .evt_hold_ms(evt_hold_ms)
`endif
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Input pattern of scenario s during cycle c.
  task automatic applyStimulus(input int s, input int c);
    reset_n    = 1'b1;
    click      = 1'b0;
    long_press = 1'b0;
    evt_ready  = 1'b1;
    case (s)
      1: click = (c == 10);
      2: click = (c == 10 || c == 13);
      3: click = (c == 10 || c == 12 || c == 14);
      4: begin
        click      = (c == 10);
        long_press = (c >= 12 && c <= 40);
      end
      5: begin
        evt_ready  = (c >= 35);
        click      = (c == 10);
        long_press = (c >= 20 && c <= 30);
      end
      6: begin
        click   = (c == 10 || c == 12 || c == 20);
        reset_n = (c != 13);
      end
      7: begin
        click      = (c == 10);
        long_press = (c >= 10 && c <= 15);
      end
      8: long_press = (c < 20);
      9: begin
        click      = (c == 10 || c == 12 || c == 14);
        long_press = (c >= 14 && c <= 17);
      end
      10: click = (c >= 10 && c <= 13);
      default: ;
    endcase
  endtask

  // Hand-derived expected outputs of scenario s during cycle c.
  task automatic getExpected(input int s, input int c, output bit v, output int t,
                             output int n, output bit ovr, output int hold);
    v = 1'b0; t = 0; n = 0; ovr = 1'b0; hold = 0;
    case (s)
      1: if (c == 16) begin v = 1; t = 0; n = 1; end
      2: if (c == 19) begin v = 1; t = 0; n = 2; end
      3: if (c == 15) begin v = 1; t = 0; n = 3; end
      4: begin
        if (c == 13) begin v = 1; t = 1; n = 1; end
        if (c == 42) begin v = 1; t = 2; n = 0; hold = 29; end
      end
      5: begin
        if (c >= 16 && c <= 35) begin v = 1; t = 0; n = 1; end
        ovr = (c >= 21);
      end
      6: if (c == 26) begin v = 1; t = 0; n = 1; end
      7: begin
        if (c == 11) begin v = 1; t = 1; n = 1; end
        if (c == 17) begin v = 1; t = 2; n = 0; hold = 6; end
      end
      8: begin
        if (c == 1)  begin v = 1; t = 1; n = 0; end
        if (c == 21) begin v = 1; t = 2; n = 0; hold = 20; end
      end
      9: begin
        if (c == 15) begin v = 1; t = 1; n = 3; end
        if (c == 19) begin v = 1; t = 2; n = 0; hold = 4; end
      end
      10: if (c == 16) begin v = 1; t = 0; n = 1; end
      default: ;
    endcase
  endtask

  task automatic startScenario(input int s);
    reset_n    = 1'b0;
    click      = 1'b0;
    long_press = (s == 8);
    evt_ready  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit v, ovr;
    int t, n, hold;
    reset_n    = 1'b0;
    click      = 1'b0;
    long_press = 1'b0;
    evt_ready  = 1'b1;
    @(posedge clk);
    #1;
    for (int s = 1; s <= 10; s++) begin
      startScenario(s);
      for (int c = 0; c < NCYC; c++) begin
        applyStimulus(s, c);
        @(negedge clk);
        getExpected(s, c, v, t, n, ovr, hold);
        checkOutput($sformatf("s%0d c%0d valid", s, c), int'(evt_valid), int'(v));
        checkOutput($sformatf("s%0d c%0d overrun", s, c), int'(evt_overrun), int'(ovr));
        if (v || c == 0) begin
          checkOutput($sformatf("s%0d c%0d type", s, c), int'(evt_type), t);
          checkOutput($sformatf("s%0d c%0d clicks", s, c), int'(evt_clicks), n);
`ifdef BTN_GESTURE_HOLD_TIME_EN
          checkOutput($sformatf("s%0d c%0d hold_ms", s, c), int'(evt_hold_ms), hold);
`endif
        end
        @(posedge clk);
        #1;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
